uart_tx_arbiter: RTL
====================

Name: uart_tx_arbiter

Overview:
- Shares one Transmitter between two byte sources:
  - Port 0 is the echo path fed by the Receiver (`rx_valid`/`rx_data`). It cannot be stalled, so it is buffered in a small FIFO.
  - Port 1 is a message source with a valid/ready handshake.
- Round-robin arbitration picks the next byte. The block drives the Transmitter's `en`/`data_tx` and sequences each byte using the Transmitter's `rdy`.
- Sits between Receiver, Transmitter and message logic at the top of the UART design.

Parameters:
- `FIFO_DEPTH`, 4, port-0 FIFO entries; power of two, 2..16.
- `BUSY_TIMEOUT`, 15, cycles to wait for `tx_rdy` to fall after a `tx_en` pulse before abandoning the transfer.

Ports:
- `clk`  in  1  system clock (32 MHz in the UART design)
- `rst`  in  1  asynchronous reset, active-high
- `rx_valid`  in  1  one-cycle pulse from Receiver: `rx_data` valid
- `rx_data`  in  8  received byte
- `msg_valid`  in  1  port-1 byte request
- `msg_data`  in  8  port-1 byte, held stable while `msg_valid`
- `msg_ready`  out  1  port-1 byte accepted this cycle (combinational)
- `tx_en`  out  1  one-cycle start pulse to Transmitter `en`
- `tx_data`  out  8  byte to Transmitter `data_tx` (registered)
- `tx_rdy`  in  1  Transmitter `rdy` (high = idle)
- `grant_src`  out  1  source of the current or most recent transfer (0 = echo, 1 = msg)
- `busy`  out  1  state != IDLE
- `fifo_count`  out  clog2(FIFO_DEPTH)+1  port-0 FIFO occupancy
- `overflow`  out  1  sticky: port-0 byte dropped
- `tx_err`  out  1  sticky: busy timeout occurred
- `err_clr`  in  1  synchronous clear of `overflow` and `tx_err`

Behaviour:
- Reset values:
  - state = IDLE.
  - `tx_en` = 0, `tx_data` = 8'h00, `grant_src` = 0, `fifo_count` = 0, `overflow` = 0, `tx_err` = 0.
  - `last_grant` = 1, so port 0 wins the first tie.
- Reset mid-transfer: the FIFO is flushed and the in-flight byte is abandoned.
- FIFO push and pop:
  - `rx_valid` pushes `rx_data` at the clock edge.
  - Push when full without a simultaneous pop: the byte is dropped and `overflow` is set.
  - Push and pop in the same cycle when full: both succeed and the count is unchanged.
  - Pop when empty never occurs, because grant requires count > 0.
- Requests: `pend0` = `fifo_count` != 0; `pend1` = `msg_valid`.
- FSM, state IDLE:
  - Grant only if `tx_rdy` = 1 and (`pend0` or `pend1`).
  - If both are pending, grant the source != `last_grant`; otherwise grant the single pending source.
  - In the grant cycle:
    - Register the FIFO head or `msg_data` into `tx_data`.
    - Pop the FIFO, or assert `msg_ready` = 1 for a port-1 grant.
    - Update `grant_src` and `last_grant`.
    - Go to ISSUE.
  - `msg_ready` is high only in a port-1 grant cycle.
- FSM, state ISSUE: `tx_en` = 1 for exactly this cycle; go to WAIT_BUSY and clear the timeout counter.
- FSM, state WAIT_BUSY:
  - `tx_rdy` = 0: go to WAIT_DONE.
  - Counter reaches `BUSY_TIMEOUT` with `tx_rdy` still 1: set `tx_err` and go to IDLE; the byte is lost.
- FSM, state WAIT_DONE: stay until `tx_rdy` = 1, then go to IDLE.
- Grant-to-`tx_en` latency: 1 cycle.
- Back-to-back transfers: the earliest regrant is the cycle after WAIT_DONE sees `tx_rdy` = 1.
- `tx_data` is held constant from ISSUE until the next grant.
- `err_clr` clears both sticky flags. If a set event occurs in the same cycle as `err_clr`, the set wins.

Optional Feature:
- Macro: `UART_ARB_STATS_EN`.
- Defined:
  - Adds outputs `cnt_echo[15:0]` and `cnt_msg[15:0]`, counting bytes granted per source (incremented in the grant cycle).
  - Both counters wrap at 16'hFFFF to 0 and reset to 0.
  - `err_clr` does not clear them.
- Undefined: the outputs and counters do not exist; all other behaviour is identical.

Test Plan:
1. Echo at 115200 baud with the real Receiver/Transmitter: send 8'd42 then 8'd88 on the serial input.
   - Required: two `tx_en` pulses with `tx_data` 8'h2A then 8'h58; `grant_src` = 0 both times; `dout` reproduces both frames.
2. Contention: FIFO holds 8'h11, `msg_valid` = 1 with 8'h22, `tx_rdy` = 1.
   - Required: first grant to port 0 (`last_grant` reset 1), then to port 1.
   - Keep both sources pending: grants alternate 0, 1, 0, 1.
3. FIFO overflow with `FIFO_DEPTH` = 4 and `tx_rdy` held 0: push 5 bytes 8'h01..8'h05.
   - Required: `fifo_count` = 4 and `overflow` = 1.
   - Release `tx_rdy`: transmitted order is 01, 02, 03, 04.
4. Full FIFO with simultaneous push and pop in the grant cycle.
   - Required: `fifo_count` stays 4; `overflow` stays 0.
5. Timeout: `tx_rdy` stuck 1 after `tx_en`.
   - Required: WAIT_BUSY lasts 15 cycles, then `tx_err` = 1 and `busy` = 0.
   - `err_clr` pulse: `tx_err` = 0.
6. Reset mid-transfer: assert `rst` during WAIT_DONE with 2 bytes in the FIFO.
   - Required: `busy`, `tx_en`, `fifo_count`, `overflow` and `tx_err` all go to 0 immediately (asynchronously); `tx_data` = 8'h00.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// ---------------------------------------------------------------------------
// uart_tx_arbiter
//   Shares one UART Transmitter between two byte sources:
//     port 0 : echo path from the Receiver (rx_valid/rx_data). It cannot be
//              stalled, so its bytes are buffered in a FIFO_DEPTH-entry FIFO.
//     port 1 : message source with a valid/ready handshake.
//   Round-robin arbitration picks the next byte. Each byte is sequenced
//   against the Transmitter's rdy: grant -> tx_en pulse -> wait for rdy to
//   fall (bounded by BUSY_TIMEOUT) -> wait for rdy to rise.
//
// Parameters
//   FIFO_DEPTH   : port-0 FIFO entries (power of two, 2..16)
//   BUSY_TIMEOUT : cycles to wait for tx_rdy to fall after tx_en
//
// Ports
//   clk, rst            : clock, asynchronous active-high reset
//   rx_valid, rx_data   : port-0 byte pulse from the Receiver
//   msg_valid, msg_data : port-1 byte request (data stable while valid)
//   msg_ready           : port-1 byte accepted this cycle (combinational)
//   tx_en, tx_data      : start pulse / registered byte to the Transmitter
//   tx_rdy              : Transmitter idle flag
//   grant_src           : source of current/most recent transfer (0 echo, 1 msg)
//   busy                : arbiter FSM not idle
//   fifo_count          : port-0 FIFO occupancy
//   overflow, tx_err    : sticky drop / busy-timeout flags
//   err_clr             : synchronous clear of the sticky flags
//
// Optional build macro UART_ARB_STATS_EN adds cnt_echo/cnt_msg, 16-bit
// wrapping counts of bytes granted per source.
// ---------------------------------------------------------------------------
module uart_tx_arbiter #(
    parameter int unsigned FIFO_DEPTH   = 4,
    parameter int unsigned BUSY_TIMEOUT = 15
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          rx_valid,
    input  logic [7:0]                    rx_data,
    input  logic                          msg_valid,
    input  logic [7:0]                    msg_data,
    output logic                          msg_ready,
    output logic                          tx_en,
    output logic [7:0]                    tx_data,
    input  logic                          tx_rdy,
    output logic                          grant_src,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          overflow,
    output logic                          tx_err,
    input  logic                          err_clr
`ifdef UART_ARB_STATS_EN
    ,
    output logic [15:0]                   cnt_echo,
    output logic [15:0]                   cnt_msg
`endif
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam int unsigned TW = $clog2(BUSY_TIMEOUT + 1);

    localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);
    localparam logic [TW-1:0] TMO_ONE  = TW'(1);
    localparam logic [TW-1:0] TMO_LAST = TW'(BUSY_TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT_BUSY,
        S_WAIT_DONE
    } state_t;

    state_t          r_state;
    state_t          w_next;

    logic [7:0]      r_mem [FIFO_DEPTH];
    logic [AW-1:0]   r_wptr;
    logic [AW-1:0]   r_rptr;
    logic [CW-1:0]   r_count;

    logic            r_tx_en;
    logic [7:0]      r_tx_data;
    logic            r_grant_src;
    logic            r_last_grant;
    logic            r_overflow;
    logic            r_tx_err;
    logic [TW-1:0]   r_tmo_cnt;

    logic            w_pend0;
    logic            w_pend1;
    logic            w_grant;
    logic            w_gsel;
    logic            w_pop;
    logic            w_full;
    logic            w_push_ok;
    logic            w_drop;
    logic            w_tmo;
    logic [7:0]      w_head;

    // ------------------------------------------------------------------
    // Port-0 FIFO
    // ------------------------------------------------------------------
    assign w_full    = (r_count == FULL_CNT);
    // A pop in the same cycle frees the slot, so a push into a full FIFO
    // still succeeds when the head is being granted.
    assign w_push_ok = rx_valid && (!w_full || w_pop);
    assign w_drop    = rx_valid && w_full && !w_pop;
    assign w_head    = r_mem[r_rptr];

    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_wptr] <= rx_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push_ok) begin
                r_wptr <= r_wptr + PTR_ONE;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + PTR_ONE;
            end
            case ({w_push_ok, w_pop})
                2'b10:   r_count <= r_count + CNT_ONE;
                2'b01:   r_count <= r_count - CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Arbitration FSM: next state and grant decode
    // ------------------------------------------------------------------
    assign w_pend0 = (r_count != '0);
    assign w_pend1 = msg_valid;

    always_comb begin
        w_next  = r_state;
        w_grant = 1'b0;
        w_gsel  = 1'b0;
        w_tmo   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (tx_rdy && (w_pend0 || w_pend1)) begin
                    w_grant = 1'b1;
                    if (w_pend0 && w_pend1) begin
                        w_gsel = ~r_last_grant;
                    end else begin
                        w_gsel = w_pend1;
                    end
                    w_next = S_ISSUE;
                end
            end
            S_ISSUE: begin
                w_next = S_WAIT_BUSY;
            end
            S_WAIT_BUSY: begin
                if (!tx_rdy) begin
                    w_next = S_WAIT_DONE;
                end else if (r_tmo_cnt == TMO_LAST) begin
                    w_tmo  = 1'b1;
                    w_next = S_IDLE;
                end
            end
            S_WAIT_DONE: begin
                if (tx_rdy) begin
                    w_next = S_IDLE;
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    assign w_pop     = w_grant && !w_gsel;
    assign msg_ready = w_grant && w_gsel;

    // ------------------------------------------------------------------
    // State register and registered datapath
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_tx_en      <= 1'b0;
            r_tx_data    <= '0;
            r_grant_src  <= 1'b0;
            r_last_grant <= 1'b1;
            r_overflow   <= 1'b0;
            r_tx_err     <= 1'b0;
            r_tmo_cnt    <= '0;
        end else begin
            r_state <= w_next;
            // Registered pulse: high exactly for the ISSUE cycle.
            r_tx_en <= w_grant;

            if (w_grant) begin
                r_tx_data    <= w_gsel ? msg_data : w_head;
                r_grant_src  <= w_gsel;
                r_last_grant <= w_gsel;
            end

            if (r_state == S_ISSUE) begin
                r_tmo_cnt <= '0;
            end else if (r_state == S_WAIT_BUSY && tx_rdy) begin
                r_tmo_cnt <= r_tmo_cnt + TMO_ONE;
            end

            // Set has priority over clear.
            if (w_drop) begin
                r_overflow <= 1'b1;
            end else if (err_clr) begin
                r_overflow <= 1'b0;
            end

            if (w_tmo) begin
                r_tx_err <= 1'b1;
            end else if (err_clr) begin
                r_tx_err <= 1'b0;
            end
        end
    end

`ifdef UART_ARB_STATS_EN
    logic [15:0] r_cnt_echo;
    logic [15:0] r_cnt_msg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt_echo <= '0;
            r_cnt_msg  <= '0;
        end else if (w_grant) begin
            if (w_gsel) begin
                r_cnt_msg <= r_cnt_msg + 16'd1;
            end else begin
                r_cnt_echo <= r_cnt_echo + 16'd1;
            end
        end
    end

    assign cnt_echo = r_cnt_echo;
    assign cnt_msg  = r_cnt_msg;
`endif

    assign tx_en      = r_tx_en;
    assign tx_data    = r_tx_data;
    assign grant_src  = r_grant_src;
    assign busy       = (r_state != S_IDLE);
    assign fifo_count = r_count;
    assign overflow   = r_overflow;
    assign tx_err     = r_tx_err;

endmodule
